// File: rtl/sample_packer.sv
// Samples one async line every clk and packs 32 samples per word (bit 0 oldest); optional internal test pattern.
// Latency: 2-flop sync, then a word every 32 clk; first word on the 32nd edge after reset release.
// Backpressure: none; the consumer latches dsq0 on negedge pclk and must keep up with one word per 32 clk.
module sample_packer #(
    parameter int TP = 100,
    parameter int TH = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sig_in,
    input  logic        test_en,
    output logic        pclk,
    output logic [31:0] dsq0,
    output logic        wvld
);

    localparam logic [15:0] TCNT_LAST = 16'(TP - 1);
    localparam logic [16:0] TH_L      = 17'(TH);

    logic        sig_s1;
    logic        s_sig;
    logic        ten_s1;
    logic        s_ten;
    logic [15:0] tcnt;
    logic        tbit;
    logic        mode;
    logic [4:0]  bcnt;
    logic [4:0]  bcnt_next;
    logic        boundary;
    logic        s;
    logic [30:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_s1 <= 1'b0;
            s_sig  <= 1'b0;
            ten_s1 <= 1'b0;
            s_ten  <= 1'b0;
        end else begin
            sig_s1 <= sig_in;
            s_sig  <= sig_s1;
            ten_s1 <= test_en;
            s_ten  <= ten_s1;
        end
    end

    // Test counter free-runs; its phase is deliberately unrelated to bcnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
        end else if (tcnt == TCNT_LAST) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 16'd1;
        end
    end

    assign tbit      = ({1'b0, tcnt} < TH_L);
    assign bcnt_next = bcnt + 5'd1;
    assign boundary  = (bcnt == 5'd31);
    assign s         = mode ? tbit : s_sig;

    // Source only changes at a word boundary so no word mixes sources.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= 1'b0;
        end else if (boundary) begin
            mode <= s_ten;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt <= '0;
            pclk <= 1'b0;
        end else begin
            bcnt <= bcnt_next;
            pclk <= ~bcnt_next[4];
        end
    end

    // Slot 31 is never stored: the newest sample goes straight into dsq0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            for (int i = 0; i < 31; i++) begin
                if (bcnt == 5'(i)) begin
                    sr[i] <= s;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsq0 <= '0;
            wvld <= 1'b0;
        end else begin
            wvld <= boundary;
            if (boundary) begin
                dsq0 <= {s, sr};
            end
        end
    end

endmodule

// File: tb/tb_sample_packer.sv
// Scoreboarded bench for sample_packer: stimulus queues expected words, a monitor checks every edge.
module tb_sample_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sig_in;
    logic        test_en;
    logic        pclk;
    logic [31:0] dsq0;
    logic        wvld;

    logic        sig_l;
    logic        sig_h;
    logic        ten_x;
    logic        pclk_l;
    logic        pclk_h;
    logic [31:0] dsq0_l;
    logic [31:0] dsq0_h;
    logic        wvld_l;
    logic        wvld_h;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] q[$];
    int          edge_no  = 0;
    logic [31:0] exp_cur  = 32'h0;

    sample_packer #(.TP(64), .TH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .test_en(test_en),
        .pclk(pclk), .dsq0(dsq0), .wvld(wvld)
    );

    sample_packer #(.TP(64), .TH(0)) u_lo (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_l), .test_en(ten_x),
        .pclk(pclk_l), .dsq0(dsq0_l), .wvld(wvld_l)
    );

    sample_packer #(.TP(64), .TH(64)) u_hi (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_h), .test_en(ten_x),
        .pclk(pclk_h), .dsq0(dsq0_h), .wvld(wvld_h)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (edge %0d, t=%0t)", name, act, exp, edge_no, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        logic exp_wvld;
        logic exp_pclk;
        int   wi;
        #1;
        if (!rst_n) begin
            edge_no = 0;
            exp_cur = 32'h0;
            chk("rst_dsq0", dsq0, 32'h0);
        end else begin
            edge_no++;
            exp_wvld = ((edge_no % 32) == 0);
            exp_pclk = ((edge_no % 32) < 16);
            chk("wvld", {31'b0, wvld}, {31'b0, exp_wvld});
            chk("pclk", {31'b0, pclk}, {31'b0, exp_pclk});
            if (wvld) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", dsq0, 32'hDEADBEEF);
                end else begin
                    exp_cur = q.pop_front();
                end
            end
            chk("dsq0", dsq0, exp_cur);
            if (exp_wvld) begin
                wi = edge_no / 32 - 1;
                chk("lo_wvld", {31'b0, wvld_l}, 32'h1);
                chk("hi_wvld", {31'b0, wvld_h}, 32'h1);
                chk("lo_pclk", {31'b0, pclk_l}, 32'h1);
                chk("hi_pclk", {31'b0, pclk_h}, 32'h1);
                chk("lo_word", dsq0_l, (wi == 0) ? 32'hFFFFFFFC : 32'h00000000);
                chk("hi_word", dsq0_h, (wi == 0) ? 32'h00000000 : 32'hFFFFFFFF);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, edge %0d", edge_no);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b1;
        sig_in  = 1'b0;
        test_en = 1'b0;
        sig_l   = 1'b1;
        sig_h   = 1'b0;
        ten_x   = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("init_dsq0", dsq0, 32'h0);
        chk("init_wvld", {31'b0, wvld}, 32'h0);
        chk("init_pclk", {31'b0, pclk}, 32'h0);

        // Constant high input.
        sig_in  = 1'b1;
        test_en = 1'b0;
        q.push_back(32'hFFFFFFFC);
        q.push_back(32'hFFFFFFFF);
        q.push_back(32'hFFFFFFFF);
        do_reset();
        repeat (96) @(negedge clk);
        chk("p1_drain", q.size(), 0);

        // Input toggling every cycle.
        q.push_back(32'hAAAAAAA8);
        q.push_back(32'hAAAAAAAA);
        q.push_back(32'hAAAAAAAA);
        q.push_back(32'hAAAAAAAA);
        do_reset();
        for (int j = 0; j < 128; j++) begin
            sig_in = j[0];
            @(negedge clk);
        end
        chk("p2_drain", q.size(), 0);

        // Test pattern selected from reset.
        sig_in  = 1'b0;
        test_en = 1'b1;
        q.push_back(32'h00000000);
        q.push_back(32'h00000000);
        q.push_back(32'h0000FFFF);
        q.push_back(32'h00000000);
        q.push_back(32'h0000FFFF);
        q.push_back(32'h00000000);
        do_reset();
        repeat (192) @(negedge clk);
        chk("p3_drain", q.size(), 0);

        // Switch to test pattern at bcnt=10.
        sig_in  = 1'b1;
        test_en = 1'b0;
        q.push_back(32'hFFFFFFFC);
        q.push_back(32'h00000000);
        q.push_back(32'h0000FFFF);
        do_reset();
        repeat (10) @(negedge clk);
        test_en = 1'b1;
        repeat (86) @(negedge clk);
        chk("p4_drain", q.size(), 0);

        // Reset at bcnt=20, held 3 cycles.
        sig_in  = 1'b1;
        test_en = 1'b0;
        q.push_back(32'hFFFFFFFC);
        do_reset();
        repeat (52) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_dsq0", dsq0, 32'h0);
        chk("arst_wvld", {31'b0, wvld}, 32'h0);
        chk("arst_pclk", {31'b0, pclk}, 32'h0);
        chk("arst_lo_dsq0", dsq0_l, 32'h0);
        chk("arst_hi_dsq0", dsq0_h, 32'h0);
        chk("p5_drain_pre", q.size(), 0);
        repeat (3) @(negedge clk);
        q.push_back(32'hFFFFFFFC);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("p5_drain", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_packer.md
# sample_packer

Front-end acquisition stage for the frequency/duty meter. It samples one asynchronous input line on every `clk`, packs 32 consecutive samples into a word, and presents that word with a derived `pclk` to the measurement/display stage. That stage latches `dsq0` on `negedge pclk`. An internal test-pattern generator can replace the external line so the meter can self-check without a signal source.

## Interface

Parameters:
- `TP`, default 100: test-pattern period in `clk` cycles (legal range 2..2^16).
- `TH`, default 25: test-pattern high time in `clk` cycles (legal range 0..TP).

Ports:
- `clk`  in  1  sample clock; all logic on `posedge clk`. One clock only.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sig_in`  in  1  asynchronous measured signal.
- `test_en`  in  1  asynchronous request to select the internal test pattern.
- `pclk`  out  1  word clock = `clk`/32, 50 % duty, registered.
- `dsq0`  out  32  packed sample word; bit 0 oldest, bit 31 newest.
- `wvld`  out  1  one-cycle pulse coincident with each `dsq0` update.

## Operation

Synchronizers:
- `sig_in` and `test_en` each pass through a 2-flop synchronizer, reset to 0.
- `s_sig` is the second-stage output of `sig_in`.
- `s_ten` is the second-stage output of `test_en`.

Test generator:
- `tcnt` (16 bit) counts 0..TP-1 and wraps. It free-runs from reset whether or not test mode is selected.
- `tbit` = (`tcnt` < TH). This is combinational from the `tcnt` register.

Source select:
- `mode` register, reset 0.
- `mode` loads `s_ten` only on the word-boundary edge (`bcnt`==31).
- Every word is therefore drawn entirely from one source.
- Sample `s` = `mode` ? `tbit` : `s_sig`.

Packing:
- `bcnt` (5 bit) increments every cycle and wraps 31→0.
- On each edge, `sr[bcnt]` <= `s` (indexed write, not shift).
- On the edge where `bcnt`==31:
  - `dsq0` <= {`s`, `sr[30:0]`};
  - `wvld` <= 1.
- On all other edges, `wvld` <= 0 and `dsq0` holds.

Word clock:
- `pclk` <= ~`bcnt_next[4]`.
- `pclk` rises on the same edge that updates `dsq0` and falls 16 cycles later.
- `dsq0` is therefore stable for 16 `clk` cycles on either side of `negedge pclk`.

Reset (asynchronous, any time, including mid-word):
- `bcnt`, `tcnt`, `sr`, `mode` and both synchronizers clear to 0.
- Outputs clear to `dsq0`=0, `wvld`=0, `pclk`=0.
- A partially filled word is discarded. There is no partial output.
- On the first edge after release, `bcnt`=0 is written and `bcnt` becomes 1.

## Timing

- Sample k of a word (k = 0..31) is taken on the edge where `bcnt`==k.
- Input-to-sample latency is 2 `clk` edges (synchronizer): a `sig_in` change that meets setup before edge n appears as `s` at edge n+2.
- First `dsq0`/`wvld` after reset: on the 32nd edge after `rst_n` deasserts. `pclk` rises on that same edge.
- Steady state: `wvld` pulses once every 32 cycles exactly, with no gaps.
- `test_en` change to `mode` latency: 2 synchronizer edges, plus a wait for the next boundary edge, which is at most 32 more edges. The word produced on the boundary edge that loads `mode` still uses the old source.
- TH=0 gives a constant-0 test pattern. TH=TP gives constant 1.
- `tcnt` wraps independently of `bcnt`. With TP not dividing 32, the pattern phase drifts across words; this is the intended behaviour.

## Test plan

1. **Constant high.** Hold `sig_in`=1 and `test_en`=0 and release reset.
   - First word (edge 32) = 0xFFFFFFFC, because bits 0..1 are synchronizer zeros.
   - Second and later words = 0xFFFFFFFF.
   - `wvld` pulses at edges 32, 64, 96.
2. **Word clock.** Toggle `sig_in` every cycle and check `pclk`/`wvld`.
   - `pclk` has period 32 and is high for 16 cycles.
   - `wvld` is high exactly on `pclk` rising edges.
   - `dsq0` is unchanged across `negedge pclk`.
   - Steady words are 0x55555555 or 0xAAAAAAAA, constant from word to word.
3. **Test pattern.** Set TP=64, TH=16, hold `test_en`=1 from reset and `sig_in`=0.
   - Word 0 = 0x00000000 (external source).
   - Word 1 = 0x00000000 (tcnt 32..63).
   - Word 2 = 0x0000FFFF.
   - Word 3 = 0x00000000, with words 2 and 3 then repeating.
4. **Mid-word mode switch.** Assert `test_en` when `bcnt`=10.
   - No `dsq0` word ever mixes sources.
   - The first test-pattern word is the one completed at the second boundary after the assertion.
5. **Reset mid-word.** Assert `rst_n`=0 at `bcnt`=20 and hold for 3 cycles.
   - `dsq0`=0, `wvld`=0 and `pclk`=0 immediately (asynchronous).
   - After release, the next `wvld` comes 32 edges later.
6. **Extremes.** TH=0 → all test words 0x00000000. TH=TP → all test words 0xFFFFFFFF.
